sipo_frame_ctrl: RTL and testbench
==================================

Name: sipo_frame_ctrl

Overview:
- Framing controller and holding stage in front of a serial-in/parallel-out shift register.
- Detects a start marker on the serial line and enables the shift register for exactly WIDTH sample cycles.
- Presents the assembled word on a valid/ready interface and flags words lost to overrun.
- Sits between the raw serial input and any parallel consumer.

Parameters:
- WIDTH, 4, data bits per frame; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  start detection allowed when 1; an in-flight frame always completes
- s_in  input  1  serial data line, sampled every clk edge
- out_ready  input  1  consumer accepts out_data
- ovr_clr  input  1  clears the sticky overrun flag
- out_data  output  WIDTH  assembled word, MSB = first received bit
- out_valid  output  1  out_data valid
- busy  output  1  state is not IDLE
- shift_en  output  1  shift register enable (combinational, = state SHIFT)
- ovr  output  1  sticky overrun flag
- par_err  output  1  parity error for the held word (PARITY_CHECK_EN only; tied 0 otherwise)

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, count=0, shift register=0.
  - out_data=0, out_valid=0, busy=0, ovr=0, par_err=0.
  - Reset mid-frame aborts the frame; no partial word is emitted.
- States: IDLE, SHIFT, PAR (feature only), HOLD.
- IDLE:
  - If en=1 and s_in=1 at edge T, go to SHIFT with count=0.
  - The start bit is not stored.
- SHIFT:
  - Each edge shifts left: sr <= {sr[WIDTH-2:0], s_in}; count++.
  - After the WIDTH-th sample (edge T+WIDTH), go to HOLD, or to PAR with the feature.
  - out_data updates only on entry to HOLD.
- Latency (no feature): out_valid=1 is visible after edge T+WIDTH; start at T, data bits sampled T+1..T+WIDTH.
- HOLD:
  - out_valid=1; out_data and par_err stable until handshake.
  - Transfer occurs on an edge where out_valid & out_ready.
  - On transfer with s_in=1 and en=1: go directly to SHIFT (back-to-back frames); otherwise go to IDLE.
  - Without transfer, s_in=1 sets ovr=1 (that start is dropped); state remains HOLD.
- ovr:
  - Cleared by ovr_clr or rst.
  - A set event and ovr_clr on the same edge: set wins.
- en=0 during SHIFT or HOLD has no effect on the current frame.
- count never exceeds WIDTH; there is no wrap.

Optional Feature:
- Macro: SIPO_FRAME_PARITY_CHECK_EN.
- When defined:
  - After the WIDTH data bits, state PAR samples one even-parity bit.
  - par_err = ^{data, parity_bit}, registered with out_data on entry to HOLD.
  - Latency becomes T+WIDTH+1.
- When undefined:
  - The PAR state and its logic are absent.
  - par_err is constant 0; latency is T+WIDTH.

Decomposition:
- Package sipo_frame_pkg: state enum (IDLE=2'd0, SHIFT=2'd1, PAR=2'd2, HOLD=2'd3).
- Sub-module sipo_shift_reg: WIDTH-bit register with clk, rst, en, s_in, q. Instantiated once, driven by shift_en.
- The FSM, counter, holding register and flags stay in sipo_frame_ctrl.

Test Plan (WIDTH=4):
- Start at T, then bits 1,0,1,1 -> out_valid=1 after T+4, out_data=4'b1011, busy=1; out_ready=1 one cycle later -> IDLE, out_valid=0.
- HOLD with out_ready=0 and s_in=1 for one cycle -> ovr=1 and out_data unchanged. Then ovr_clr=1 -> ovr=0. Then ovr_clr and a new overrun on the same edge -> ovr=1.
- Transfer edge with s_in=1, en=1 -> next state SHIFT; second frame 0,1,1,0 -> out_data=4'b0110 with no idle gap.
- en=0 with s_in=1 in IDLE -> stays IDLE; en dropped mid-frame -> frame still completes with the correct word.
- rst asserted after 2 data bits -> all outputs 0 next cycle, no out_valid; a subsequent clean frame 1,1,0,1 -> 4'b1101.
- With SIPO_FRAME_PARITY_CHECK_EN: data 1,0,1,1 with parity 1 -> par_err=0, valid after T+5; parity 0 -> par_err=1.

Source files
------------

// File: rtl/sipo_frame_pkg.sv
// Shared types for the serial framing controller: FSM state encoding.
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register; the first bit shifted in ends up as the MSB.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s_in,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], s_in};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Start-marker framing FSM, holding register and overrun flag around sipo_shift_reg.
// Optional even-parity check stage enabled by defining SIPO_FRAME_PARITY_CHECK_EN.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s_in,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             shift_en,
  output logic             ovr,
  output logic             par_err
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] hold_data_d;
  logic             hold_load;
  logic             ovr_set;
`ifdef SIPO_FRAME_PARITY_CHECK_EN
  logic             par_err_d;
`endif

  sipo_shift_reg #(.WIDTH(WIDTH)) u_shift_reg (
    .clk  (clk),
    .rst  (rst),
    .en   (shift_en),
    .s_in (s_in),
    .q    (sr_q)
  );

  assign shift_en  = (state_q == SHIFT);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == HOLD);

  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    hold_load   = 1'b0;
    hold_data_d = sr_q;
    ovr_set     = 1'b0;
`ifdef SIPO_FRAME_PARITY_CHECK_EN
    par_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && s_in) begin
          state_d = SHIFT;
          count_d = '0;
        end
      end
      SHIFT: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_FRAME_PARITY_CHECK_EN
          state_d = PAR;
`else
          // The last bit is still on s_in; capture the word the shifter is about to hold.
          state_d     = HOLD;
          hold_load   = 1'b1;
          hold_data_d = {sr_q[WIDTH-2:0], s_in};
`endif
        end
      end
`ifdef SIPO_FRAME_PARITY_CHECK_EN
      PAR: begin
        state_d   = HOLD;
        hold_load = 1'b1;
        par_err_d = ^{sr_q, s_in};
      end
`endif
      HOLD: begin
        if (out_ready) begin
          if (en && s_in) begin
            state_d = SHIFT;
            count_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (s_in) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      out_data <= '0;
      ovr      <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (hold_load) begin
        out_data <= hold_data_d;
      end
      // A new overrun outranks a simultaneous clear.
      if (ovr_set) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end
    end
  end

`ifdef SIPO_FRAME_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (hold_load) begin
      par_err <= par_err_d;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl (WIDTH=4): directed frames, overrun, back-to-back, reset abort.
module tb_sipo_frame_ctrl;
  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         pe;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         s_in = 1'b0;
  logic         out_ready = 1'b0;
  logic         ovr_clr = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid, busy, shift_en, ovr, par_err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .s_in      (s_in),
    .out_ready (out_ready),
    .ovr_clr   (ovr_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .shift_en  (shift_en),
    .ovr       (ovr),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic s, input logic r, input logic c);
    en = e; s_in = s; out_ready = r; ovr_clr = c;
    @(posedge clk);
    #1;
  endtask

  // Data bits (MSB first) plus a parity bit when the feature is built in.
  task automatic send_bits(input logic [W-1:0] bits, input logic e, input logic p);
    exp_t x;
    x.data = bits;
`ifdef SIPO_FRAME_PARITY_CHECK_EN
    x.pe = ^{bits, p};
`else
    x.pe = 1'b0;
`endif
    sb.push_back(x);
    for (int i = W - 1; i >= 0; i--) begin
      cyc(e, bits[i], 1'b0, 1'b0);
      if (i == 1) check("valid_early", out_valid, 0);
    end
`ifdef SIPO_FRAME_PARITY_CHECK_EN
    check("valid_before_par", out_valid, 0);
    cyc(e, p, 1'b0, 1'b0);
`else
    if (p) check("unused_parity", 0, 0 & p);
`endif
    check("valid_at_latency", out_valid, 1);
    check("busy_hold", busy, 1);
    check("shift_en_hold", shift_en, 0);
  endtask

  // Monitor: on every transfer cycle pop the expected word and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {28'd0, out_data}, 32'hffff_ffff);
        end else begin
          exp_t x;
          x = sb.pop_front();
          check("out_data", {28'd0, out_data}, {28'd0, x.data});
          check("par_err", par_err, x.pe);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_shift_en", shift_en, 0);
    check("rst_ovr", ovr, 0);
    check("rst_par_err", par_err, 0);
    check("rst_data", {28'd0, out_data}, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);

    // Basic frame 1011, handshake one cycle later
    cyc(1, 1, 0, 0);
    check("busy_shift", busy, 1);
    check("shift_en_shift", shift_en, 1);
    send_bits(4'b1011, 1'b1, 1'b1);
    cyc(1, 0, 0, 0);
    check("hold_waits", out_valid, 1);
    cyc(1, 0, 1, 0);
    check("idle_after_xfer", busy, 0);
    check("valid_after_xfer", out_valid, 0);

    // Overrun: dropped start sets ovr, clear, then set-wins-over-clear
    cyc(1, 1, 0, 0);
    send_bits(4'b1001, 1'b1, 1'b0);
    cyc(1, 1, 0, 0);
    check("ovr_set", ovr, 1);
    check("ovr_still_hold", out_valid, 1);
    cyc(1, 0, 0, 1);
    check("ovr_cleared", ovr, 0);
    cyc(1, 1, 0, 1);
    check("ovr_set_wins", ovr, 1);
    cyc(1, 0, 0, 1);
    check("ovr_cleared2", ovr, 0);
    cyc(1, 0, 1, 0);
    check("idle_after_ovr", busy, 0);

    // Back-to-back frames 1011 then 0110
    cyc(1, 1, 0, 0);
    send_bits(4'b1011, 1'b1, 1'b1);
    cyc(1, 1, 1, 0);
    check("b2b_shift", shift_en, 1);
    check("b2b_valid", out_valid, 0);
    send_bits(4'b0110, 1'b1, 1'b0);
    cyc(1, 0, 1, 0);
    check("b2b_idle", busy, 0);
    check("b2b_no_ovr", ovr, 0);

    // en=0 blocks start in IDLE; en dropping mid-frame does not
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check("en0_idle", busy, 0);
    cyc(1, 1, 0, 0);
    send_bits(4'b0011, 1'b0, 1'b0);
    cyc(0, 1, 1, 0);
    check("en0_xfer_to_idle", busy, 0);

    // Reset after two data bits aborts; then a clean frame 1101
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    rst = 1'b1;
    cyc(1, 1, 0, 0);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", {28'd0, out_data}, 0);
    check("abort_ovr", ovr, 0);
    rst = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("abort_no_valid", out_valid, 0);
    cyc(1, 1, 0, 0);
    send_bits(4'b1101, 1'b1, 1'b1);
    cyc(1, 0, 1, 0);

`ifdef SIPO_FRAME_PARITY_CHECK_EN
    // Parity: 1011 with parity 1 is good, with parity 0 is an error
    cyc(1, 1, 0, 0);
    send_bits(4'b1011, 1'b1, 1'b1);
    check("par_ok", par_err, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    send_bits(4'b1011, 1'b1, 1'b0);
    check("par_bad", par_err, 1);
    cyc(1, 0, 1, 0);
`endif

    cyc(0, 0, 0, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
